cpu_sequencer: RTL

- Multi-cycle sequencer for the RV32I datapath.
- Steps each instruction through FETCH, DECODE, EXEC, optional MEM, then WB.
- Issues the instruction/data memory request handshakes.
- Gates the per-instruction strobes from the instruction decoder (register-file write, DMEM write) so they fire exactly once per instruction, in the correct cycle.
- Also owns the retired-instruction counter, the memory-timeout watchdog and the sticky fault state.

---
 rtl/cpu_sequencer_if.sv | 30 +++
 rtl/cpu_sequencer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/cpu_sequencer_if.sv
// Memory handshake bundle between the multi-cycle sequencer and the
// instruction/data memories.
//   imem_req  : sequencer -> imem, fetch request (held for the whole fetch)
//   imem_ack  : imem -> sequencer, fetch data valid this cycle
//   dmem_req  : sequencer -> dmem, data access request
//   dmem_we   : sequencer -> dmem, write enable, meaningful only with dmem_req
//   dmem_ack  : dmem -> sequencer, data access completes this cycle
interface cpu_sequencer_if;
    logic imem_req;
    logic imem_ack;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;

    modport master (
        output imem_req,
        input  imem_ack,
        output dmem_req,
        output dmem_we,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        output imem_ack,
        input  dmem_req,
        input  dmem_we,
        output dmem_ack
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle sequencer for the RV32I datapath. Walks each instruction
// through FETCH, DECODE, EXEC, optional MEM and WB, issues the memory
// handshakes, gates the decoder's write strobes so each fires once per
// instruction, counts retired instructions and traps stuck memory accesses
// into a sticky FAULT state that only reset leaves.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   start, halt_req    : leave IDLE / return to IDLE after the next retire
//   bus (master)       : imem/dmem request-acknowledge handshakes
//   ir_load            : instruction register load pulse (imem_ack in FETCH)
//   dec_*              : per-instruction flags from the instruction decoder
//   rf_we, pc_we       : register-file and PC write strobes (WB only)
//   retire, instret    : retire pulse and retired-instruction counter
//   state, fault       : FSM state code and sticky fault flag
module cpu_sequencer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int WAIT_W         = 5,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             halt_req,
    cpu_sequencer_if.master  bus,
    output logic             ir_load,
    input  logic             dec_w_en_rf,
    input  logic             dec_wr_en_dmem,
    input  logic             dec_is_load,
    input  logic             dec_illegal,
    output logic             rf_we,
    output logic             pc_we,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state,
    output logic             fault
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd6,
        S_UNUSED = 3'd7
    } state_t;

    // Watchdog value seen in the last permitted ack-less cycle.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    state_t             state_reg;
    state_t             state_next;
    logic [WAIT_W-1:0]  wait_reg;
    logic [WAIT_W-1:0]  wait_next;
    logic [CNT_W-1:0]   instret_reg;
    logic               imem_req_reg;
    logic               dmem_req_reg;
    logic               wb_reg;
    logic               fault_reg;
    logic               limit_hit;

    assign limit_hit = (TIMEOUT_CYCLES != 0) && (wait_reg == WAIT_LAST);

    // The watchdog is zero in every state except while a FETCH or MEM is
    // waiting, so each entry into those states starts from zero. An ack is
    // checked before the limit, so an ack in the final cycle still wins.
    always_comb begin
        state_next = state_reg;
        wait_next  = '0;
        case (state_reg)
            S_IDLE: begin
                if (start) state_next = S_FETCH;
            end
            S_FETCH: begin
                if (bus.imem_ack)   state_next = S_DECODE;
                else if (limit_hit) state_next = S_FAULT;
                else                wait_next  = wait_reg + WAIT_W'(1);
            end
            S_DECODE: begin
                state_next = dec_illegal ? S_FAULT : S_EXEC;
            end
            S_EXEC: begin
                state_next = (dec_is_load || dec_wr_en_dmem) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (bus.dmem_ack)   state_next = S_WB;
                else if (limit_hit) state_next = S_FAULT;
                else                wait_next  = wait_reg + WAIT_W'(1);
            end
            S_WB: begin
                state_next = halt_req ? S_IDLE : S_FETCH;
            end
            S_FAULT: begin
                state_next = S_FAULT;
            end
            default: begin
                state_next = S_FAULT;
            end
        endcase
    end

    // Moore outputs are registered from the next state so they line up
    // exactly with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            wait_reg     <= '0;
            instret_reg  <= '0;
            imem_req_reg <= 1'b0;
            dmem_req_reg <= 1'b0;
            wb_reg       <= 1'b0;
            fault_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_reg     <= wait_next;
            if (state_reg == S_WB) begin
                instret_reg <= instret_reg + CNT_W'(1);
            end
            imem_req_reg <= (state_next == S_FETCH);
            dmem_req_reg <= (state_next == S_MEM);
            wb_reg       <= (state_next == S_WB);
            fault_reg    <= (state_next == S_FAULT);
        end
    end

    // Decoder flags are only honoured inside the state that owns them.
    assign bus.imem_req = imem_req_reg;
    assign bus.dmem_req = dmem_req_reg;
    assign bus.dmem_we  = dmem_req_reg & dec_wr_en_dmem;
    assign ir_load      = imem_req_reg & bus.imem_ack;
    assign rf_we        = wb_reg & dec_w_en_rf;
    assign pc_we        = wb_reg;
    assign retire       = wb_reg;
    assign instret      = instret_reg;
    assign state        = state_reg;
    assign fault        = fault_reg;
endmodule
